// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues the PC to instruction memory with one
// request outstanding and buffers responses in a small queue toward decode.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_en,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   req_pc;
  logic [PTR_W-1:0]        head, tail;
  logic [CNT_W-1:0]        count;
  logic [DATA_WIDTH-1:0]   instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];

  logic grant;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // A slot is free only when nothing is outstanding, so a granted fetch
  // always has room to land even if decode stalls meanwhile.
  assign imem_req  = (state == ST_IDLE) & (count < FULL_COUNT) & ~flush & ~rst;
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;
  assign pc_en     = ~rst & (flush | grant);

  assign push = (state == ST_WAIT) & imem_rvalid & ~flush;
  assign pop  = if_valid & if_ready & ~flush;

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? instr_mem[head] : '0;
  assign if_pc    = if_valid ? pc_mem[head]    : '0;

  // NOTE: next-state logic assigns a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (grant) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)            state_next = imem_rvalid ? ST_IDLE : ST_DISCARD;
        else if (imem_rvalid) state_next = ST_IDLE;
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_pc <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (grant) req_pc <= pc;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= next_ptr(tail);
        if (pop)  head <= next_ptr(head);
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage carries no reset; outputs are gated by if_valid, so
  // stale entries are never visible and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= imem_rdata;
      pc_mem[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected decode entries into
// a scoreboard, and an independent monitor checks every accepted head entry.
module tb_fetch_unit;

  localparam logic [31:0] BOOT = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush = 1'b0;
  logic [31:0] pc_branch = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  // Program counter the fetch unit steers: +4 on accepted fetch, target on flush.
  always @(posedge clk or posedge rst) begin
    if (rst)        pc <= BOOT;
    else if (pc_en) pc <= flush ? pc_branch : pc + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every entry decode accepts must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("if_pc", if_pc, e.addr);
        check("if_instr", if_instr, e.instr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [31:0] addr);
    imem_gnt = 1'b1;
    #1;
    check("req_at_grant", {31'd0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, addr);
    check("pc_en_grant", {31'd0, pc_en}, 32'd1);
    next_cycle();
    imem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] addr, input logic [31:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    #1;
    check("req_while_wait", {31'd0, imem_req}, 32'd0);
    check("pc_en_wait", {31'd0, pc_en}, 32'd0);
    sb.push_back('{addr: addr, instr: data});
    next_cycle();
    imem_rvalid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    grant(addr);
    respond(addr, data);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    @(posedge clk);
    next_cycle();
    rst = 1'b0;

    // Reset then fetch, back to back
    if_ready = 1'b1;
    fetch(BOOT,              32'h1111_1111);
    fetch(BOOT + 32'h4,      32'h2222_2222);
    fetch(BOOT + 32'h8,      32'h3333_3333);
    next_cycle();

    // Backpressure
    if_ready = 1'b0;
    fetch(BOOT + 32'hC,  32'h4444_4444);
    fetch(BOOT + 32'h10, 32'h5555_5555);
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_req", {31'd0, imem_req}, 32'd0);
      check("full_pc_en", {31'd0, pc_en}, 32'd0);
      next_cycle();
    end
    check("pc_frozen", pc, BOOT + 32'h14);
    if_ready = 1'b1;
    #1;
    check("full_req_pop", {31'd0, imem_req}, 32'd0);
    next_cycle();
    if_ready = 1'b0;
    fetch(BOOT + 32'h14, 32'h6666_6666);
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("one_req_only", {31'd0, imem_req}, 32'd0);
      next_cycle();
    end
    imem_gnt = 1'b0;
    if_ready = 1'b1;
    repeat (3) next_cycle();
    check("drained_valid", {31'd0, if_valid}, 32'd0);

    // Flush from IDLE, then flush during WAIT
    if_ready  = 1'b0;
    flush     = 1'b1;
    pc_branch = BOOT;
    sb.delete();
    #1;
    check("idle_flush_req", {31'd0, imem_req}, 32'd0);
    check("idle_flush_pc_en", {31'd0, pc_en}, 32'd1);
    next_cycle();
    flush = 1'b0;
    fetch(BOOT, 32'h1000_0001);
    grant(BOOT + 32'h4);
    flush     = 1'b1;
    pc_branch = BOOT + 32'h100;
    sb.delete();
    #1;
    check("wait_flush_pc_en", {31'd0, pc_en}, 32'd1);
    check("wait_flush_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("flush_empty", {31'd0, if_valid}, 32'd0);
    check("discard_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("discard_rsp_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    imem_rvalid = 1'b0;
    #1;
    check("stale_dropped", {31'd0, if_valid}, 32'd0);
    fetch(BOOT + 32'h100, 32'h7777_7777);

    // Flush coincident with response and decode pop
    grant(BOOT + 32'h104);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    flush       = 1'b1;
    pc_branch   = BOOT + 32'h200;
    if_ready    = 1'b1;
    sb.delete();
    #1;
    check("same_cycle_pc_en", {31'd0, pc_en}, 32'd1);
    next_cycle();
    imem_rvalid = 1'b0;
    flush       = 1'b0;
    if_ready    = 1'b0;
    #1;
    check("same_cycle_empty", {31'd0, if_valid}, 32'd0);
    check("same_cycle_req", {31'd0, imem_req}, 32'd1);
    check("same_cycle_addr", imem_addr, BOOT + 32'h200);

    // Push and pop together while the tail wraps
    fetch(BOOT + 32'h200, 32'h8888_8888);
    grant(BOOT + 32'h204);
    if_ready = 1'b1;
    respond(BOOT + 32'h204, 32'h9999_9999);
    if_ready = 1'b0;
    #1;
    check("wrap_valid", {31'd0, if_valid}, 32'd1);
    check("wrap_if_pc", if_pc, BOOT + 32'h204);
    check("wrap_if_instr", if_instr, 32'h9999_9999);

    // Asynchronous reset while a request is outstanding
    grant(BOOT + 32'h208);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_if_valid", {31'd0, if_valid}, 32'd0);
    check("arst_imem_req", {31'd0, imem_req}, 32'd0);
    check("arst_if_instr", if_instr, 32'd0);
    check("arst_if_pc", if_pc, 32'd0);
    next_cycle();
    check("arst_pc_en", {31'd0, pc_en}, 32'd0);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_CAFE;
    next_cycle();
    imem_rvalid = 1'b0;
    #1;
    check("late_rsp_ignored", {31'd0, if_valid}, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, BOOT);
    if_ready = 1'b1;
    fetch(BOOT, 32'hAAAA_AAAA);
    repeat (3) next_cycle();
    check("final_empty", {31'd0, if_valid}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
